// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared constants and types for the writeback collector slice.
//   XLEN        default result data width
//   ADDR_W      default register address width
//   NUM_WR_MAX  maximum number of register-file write ports
//   wb_req_t    one writeback request {addr, data}
//   rr_next     round-robin successor of a slot index
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_WR_MAX = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_collector_if.sv
// -----------------------------------------------------------------------------
// wb_collector_if
// Bundles the result-source handshake and the register-file write ports of the
// writeback collector.
//   src_valid/src_ready  per-source valid/ready handshake
//   src_addr/src_data    per-source destination register and result (flattened)
//   wr_en/wr_addr/wr_data register-file write ports (flattened)
// Modports:
//   master  the execution-unit / register-file side
//   slave   the collector
// -----------------------------------------------------------------------------
interface wb_collector_if #(
  parameter int NUM_SRC = 6,
  parameter int NUM_WR  = wb_pkg::NUM_WR_MAX,
  parameter int XLEN    = wb_pkg::XLEN,
  parameter int ADDR_W  = wb_pkg::ADDR_W
);

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*XLEN-1:0]   src_data;
  logic [NUM_WR-1:0]         wr_en;
  logic [NUM_WR*ADDR_W-1:0]  wr_addr;
  logic [NUM_WR*XLEN-1:0]    wr_data;

  modport master (
    output src_valid, src_addr, src_data,
    input  src_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  src_valid, src_addr, src_data,
    output src_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/wb_rr_picker.sv
// -----------------------------------------------------------------------------
// wb_rr_picker
// Combinational round-robin arbiter for the writeback slots. Scans slots from
// rr_ptr upward (mod NUM_SRC) and grants each valid slot that can be retired
// this cycle: address-0 slots are dropped without a port when ZERO_DROP != 0,
// other slots need a free port and an address distinct from every address
// already granted a port this cycle.
// Ports:
//   hold_v     in   valid flag per slot
//   hold_addr  in   destination address per slot
//   rr_ptr     in   first slot to consider
//   grant      out  slot retires this cycle
//   port_used  out  write port k carries a granted slot
//   port_src   out  slot index driving write port k
//   any_grant  out  at least one slot granted
//   last_idx   out  last granted slot in scan order
// -----------------------------------------------------------------------------
module wb_rr_picker #(
  parameter int NUM_SRC   = 6,
  parameter int NUM_WR    = 4,
  parameter int ADDR_W    = 5,
  parameter int ZERO_DROP = 1,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_SRC-1:0] hold_v,
  input  logic [ADDR_W-1:0]  hold_addr [NUM_SRC],
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [NUM_WR-1:0]  port_used,
  output logic [IDX_W-1:0]   port_src [NUM_WR],
  output logic               any_grant,
  output logic [IDX_W-1:0]   last_idx
);
  import wb_pkg::*;

  always_comb begin : pick
    int unsigned        idx;
    int                 nport;
    logic               clash;
    logic [NUM_SRC-1:0] wr_grant;

    grant     = '0;
    port_used = '0;
    for (int k = 0; k < NUM_WR; k++) port_src[k] = '0;
    any_grant = 1'b0;
    last_idx  = '0;
    wr_grant  = '0;
    nport     = 0;
    clash     = 1'b0;
    idx       = 32'(rr_ptr);

    for (int off = 0; off < NUM_SRC; off++) begin
      if (hold_v[idx]) begin
        if (ZERO_DROP != 0 && hold_addr[idx] == '0) begin
          grant[idx] = 1'b1;
          any_grant  = 1'b1;
          last_idx   = IDX_W'(idx);
        end else if (nport < NUM_WR) begin
          // Only slots that own a port this cycle can block a later one.
          clash = 1'b0;
          for (int j = 0; j < NUM_SRC; j++) begin
            if (wr_grant[j] && hold_addr[j] == hold_addr[idx]) clash = 1'b1;
          end
          if (!clash) begin
            grant[idx]      = 1'b1;
            wr_grant[idx]   = 1'b1;
            port_used[nport] = 1'b1;
            port_src[nport]  = IDX_W'(idx);
            nport           = nport + 1;
            any_grant       = 1'b1;
            last_idx        = IDX_W'(idx);
          end
        end
      end
      idx = rr_next(idx, 32'(NUM_SRC));
    end
  end

endmodule

// File: rtl/wb_collector.sv
// -----------------------------------------------------------------------------
// wb_collector
// Writeback collector in front of the multi-port integer register file. Each
// of NUM_SRC execution units owns one holding slot; a result accepted at an
// edge is written to the register file from the following cycle, with up to
// NUM_WR writes per cycle, round-robin fairness and never two writes to the
// same address in one cycle.
// Optional feature macro: WB_PERF_EN adds perf_stall/perf_defer counters.
// Ports:
//   clk         clock
//   rst_n       synchronous reset, active-low
//   bus         wb_collector_if.slave (source handshake + write ports)
//   busy        any slot holds a result
//   perf_stall  [WB_PERF_EN] cycles with a source valid but not ready
//   perf_defer  [WB_PERF_EN] cycles with at least one same-address deferral
// -----------------------------------------------------------------------------
module wb_collector #(
  parameter int NUM_SRC   = 6,
  parameter int NUM_WR    = 4,
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_DROP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_collector_if.slave     bus,
  output logic              busy
`ifdef WB_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_defer
`endif
);
  import wb_pkg::*;

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] hold_v_q, hold_v_d;
  logic [ADDR_W-1:0]  hold_addr_q [NUM_SRC];
  logic [ADDR_W-1:0]  hold_addr_d [NUM_SRC];
  logic [XLEN-1:0]    hold_data_q [NUM_SRC];
  logic [XLEN-1:0]    hold_data_d [NUM_SRC];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] hs;
  logic [NUM_WR-1:0]  port_used;
  logic [IDX_W-1:0]   port_src [NUM_WR];
  logic               any_grant;
  logic [IDX_W-1:0]   last_idx;

  wb_rr_picker #(
    .NUM_SRC   (NUM_SRC),
    .NUM_WR    (NUM_WR),
    .ADDR_W    (ADDR_W),
    .ZERO_DROP (ZERO_DROP),
    .IDX_W     (IDX_W)
  ) u_picker (
    .hold_v    (hold_v_q),
    .hold_addr (hold_addr_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .port_used (port_used),
    .port_src  (port_src),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  // A slot retiring this cycle can take a new result at the same edge, so
  // ready depends only on registered state, never on src_valid.
  assign bus.src_ready = rst_n ? (~hold_v_q | grant) : '0;
  assign hs            = bus.src_valid & bus.src_ready;
  assign busy          = rst_n & (|hold_v_q);

  always_comb begin
    hold_v_d = (hold_v_q & ~grant) | hs;
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_addr_d[i] = hold_addr_q[i];
      hold_data_d[i] = hold_data_q[i];
      if (hs[i]) begin
        hold_addr_d[i] = bus.src_addr[i*ADDR_W +: ADDR_W];
        hold_data_d[i] = bus.src_data[i*XLEN +: XLEN];
      end
    end
    rr_ptr_d = any_grant ? IDX_W'(rr_next(32'(last_idx), 32'(NUM_SRC))) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Slot payload is qualified by hold_v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_addr_q <= hold_addr_d;
    hold_data_q <= hold_data_d;
  end

  always_comb begin
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (rst_n && port_used[k]) begin
        bus.wr_en[k]                      = 1'b1;
        bus.wr_addr[k*ADDR_W +: ADDR_W]   = hold_addr_q[port_src[k]];
        bus.wr_data[k*XLEN +: XLEN]       = hold_data_q[port_src[k]];
      end
    end
  end

`ifdef WB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_defer_q, perf_defer_d;
  logic        stall_any;
  logic        defer_any;

  // A deferral is a pending slot that lost only because an earlier slot in
  // scan order already owns a port for the same address.
  always_comb begin
    stall_any = |(bus.src_valid & ~bus.src_ready);
    defer_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (hold_v_q[i] && !grant[i] && !(ZERO_DROP != 0 && hold_addr_q[i] == '0)) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          if (j != i && grant[j] && hold_addr_q[j] == hold_addr_q[i]) defer_any = 1'b1;
        end
      end
    end
    perf_stall_d = stall_any ? sat_inc(perf_stall_q) : perf_stall_q;
    perf_defer_d = defer_any ? sat_inc(perf_defer_q) : perf_defer_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_defer_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_defer_q <= perf_defer_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_defer = perf_defer_q;
`endif

endmodule
